// File: rtl/ladner_fischer_adder_16bit.sv
// 16-bit Ladner-Fischer prefix adder with registered sum and carry-out.
// Four explicit prefix levels. P is only kept for groups that do not yet reach bit 0.
module ladner_fischer_adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Cout
);

  logic [4:0][15:0] w_g;
  logic [15:0]      w_p0;
  logic [15:2]      w_p1;
  logic [15:4]      w_p2;
  logic [15:8]      w_p3;
  logic [15:0]      w_sum;
  logic [15:0]      r_sum;
  logic             r_cout;

  assign w_g[0] = A & B;
  assign w_p0   = A ^ B;

  // Each level combines node i with node (block base - 1) when bit l of i is set.
  // A cell is gray once its group reaches bit 0 (i < 2^(l+1)).
  for (genvar i = 0; i < 16; i++) begin : g_lvl0
    if (i[0]) begin : g_cell
      assign w_g[1][i] = w_g[0][i] | (w_p0[i] & w_g[0][i-1]);
      if (i >= 2) begin : g_blk
        assign w_p1[i] = w_p0[i] & w_p0[i-1];
      end
    end else begin : g_pass
      assign w_g[1][i] = w_g[0][i];
      if (i >= 2) begin : g_pp
        assign w_p1[i] = w_p0[i];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl1
    localparam int J = ((i >> 1) << 1) - 1;
    if (i[1]) begin : g_cell
      assign w_g[2][i] = w_g[1][i] | (w_p1[i] & w_g[1][J]);
      if (i >= 4) begin : g_blk
        assign w_p2[i] = w_p1[i] & w_p1[J];
      end
    end else begin : g_pass
      assign w_g[2][i] = w_g[1][i];
      if (i >= 4) begin : g_pp
        assign w_p2[i] = w_p1[i];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl2
    localparam int J = ((i >> 2) << 2) - 1;
    if (i[2]) begin : g_cell
      assign w_g[3][i] = w_g[2][i] | (w_p2[i] & w_g[2][J]);
      if (i >= 8) begin : g_blk
        assign w_p3[i] = w_p2[i] & w_p2[J];
      end
    end else begin : g_pass
      assign w_g[3][i] = w_g[2][i];
      if (i >= 8) begin : g_pp
        assign w_p3[i] = w_p2[i];
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl3
    if (i[3]) begin : g_cell
      assign w_g[4][i] = w_g[3][i] | (w_p3[i] & w_g[3][7]);
    end else begin : g_pass
      assign w_g[4][i] = w_g[3][i];
    end
  end

  assign w_sum = w_p0 ^ {w_g[4][14:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= 16'h0000;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_g[4][15];
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_ladner_fischer_adder_16bit.sv
// Directed and random checks of the registered 16-bit prefix adder.
module tb_ladner_fischer_adder_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Sum;
  logic        Cout;

  int checks = 0;
  int errors = 0;

  ladner_fischer_adder_16bit dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Sum (Sum),
    .Cout(Cout)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert ({Cout, Sum} === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, {Cout, Sum}, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          rerr;
    rst = 1'b1;
    A   = 16'h0000;
    B   = 16'h0000;
    #1;
    chk("reset_t1", 17'h00000);
    #19;
    chk("reset_t20", 17'h00000);
    @(posedge clk);
    #1;
    chk("reset_edge", 17'h00000);

    @(negedge clk);
    rst = 1'b0;
    A = 16'h0A0A;
    B = 16'h0505;
    @(posedge clk);
    #1;
    chk("first_after_release", 17'h00F0F);

    apply("plain_1234", 16'h1234, 16'h0000, 17'h01234);
    apply("full_carry", 16'hFFFF, 16'h0001, 17'h10000);
    apply("msb_pair",   16'h8000, 16'h8000, 17'h10000);
    apply("max_case",   16'hFFFF, 16'hFFFF, 17'h1FFFE);
    apply("alt_bits",   16'hAAAA, 16'h5555, 17'h0FFFF);
    apply("mid_carry",  16'h00FF, 16'h0001, 17'h00100);
    apply("mixed",      16'h1234, 16'hEDCC, 17'h10000);
    apply("zero",       16'h0000, 16'h0000, 17'h00000);
    apply("held_a",     16'h7FFF, 16'h0001, 17'h08000);
    @(posedge clk);
    #1;
    chk("held_b", 17'h08000);

    apply("pre_reset", 16'hFFFF, 16'hFFFF, 17'h1FFFE);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset", 17'h00000);
    A = 16'h1111;
    B = 16'h2222;
    @(posedge clk);
    #1;
    chk("reset_overrides_edge", 17'h00000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("released_no_edge", 17'h00000);
    @(posedge clk);
    #1;
    chk("post_release_load", 17'h03333);

    rerr = 0;
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      @(negedge clk);
      A = ra;
      B = rb;
      @(posedge clk);
      #1;
      checks++;
      assert ({Cout, Sum} === ({1'b0, ra} + {1'b0, rb}))
      else begin
        errors++;
        rerr++;
        if (rerr <= 10)
          $error("FAIL random a=%h b=%h observed=%h expected=%h", ra, rb, {Cout, Sum},
                 {1'b0, ra} + {1'b0, rb});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
